// File: rtl/semaforo_multi.sv
// Multi-approach traffic light controller: round-robin right of way with
// demand-driven green, yellow and all-red clearance phases plus pedestrian walk.
//
// state     | meaning
// ST_GREEN  | active approach has green (walk too if a ped call was latched)
// ST_YELLOW | active approach shows yellow, walk off
// ST_ALLRED | every approach red, clearance before next green
module semaforo_multi #(
    parameter int N_APP    = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int T_GMIN   = 5,
    parameter int T_GMAX   = 15,
    parameter int T_YEL    = 3,
    parameter int T_ARED   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [N_APP-1:0] sensor_i,
    input  logic [N_APP-1:0] ped_req_i,
    output logic [N_APP-1:0] green_o,
    output logic [N_APP-1:0] yellow_o,
    output logic [N_APP-1:0] red_o,
    output logic [N_APP-1:0] walk_o,
    output logic [2:0]       active_o,
    output logic [3:0]       countdown_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [N_APP-1:0] ONE = {{(N_APP-1){1'b0}}, 1'b1};
    localparam logic [3:0] CD_RST = (T_GMIN > 15) ? 4'd15 : 4'(T_GMIN);

    typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [7:0]       timer_q, timer_d, timer_inc;
    logic [2:0]       active_q, active_d, rr_next;
    logic [N_APP-1:0] ped_lat_q, ped_lat_d;
    logic             walk_flag_q, walk_flag_d;
    logic [N_APP-1:0] demand, act_mask, act_mask_d;
    logic             other_dem;
    logic [7:0]       rem;
    logic [3:0]       cd_d;
    logic [N_APP-1:0] green_d, yellow_d, red_d, walk_d;

    assign tick      = enable_i && (presc_q == PW'(TICK_DIV - 1));
    assign timer_inc = timer_q + 8'd1;
    assign demand    = sensor_i | ped_lat_q;
    assign act_mask  = ONE << active_q;
    assign other_dem = |(demand & ~act_mask);

    always_comb begin
        presc_d = presc_q;
        if (enable_i) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Descending scan so the nearest demanding approach after active wins.
    always_comb begin
        rr_next = 3'((int'(active_q) + 1) % N_APP);
        for (int k = N_APP - 1; k >= 1; k--) begin
            if (|(demand & (ONE << ((int'(active_q) + k) % N_APP)))) begin
                rr_next = 3'((int'(active_q) + k) % N_APP);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        active_d    = active_q;
        walk_flag_d = walk_flag_q;
        ped_lat_d   = ped_lat_q | ped_req_i;
        if (tick) begin
            timer_d = timer_inc;
            case (state_q)
                ST_GREEN: begin
                    if (other_dem && (timer_inc >= 8'(T_GMIN))) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end else if (timer_inc == 8'(T_GMAX)) begin
                        timer_d = '0;
                    end
                end
                ST_YELLOW: begin
                    if (timer_inc == 8'(T_YEL)) begin
                        state_d     = ST_ALLRED;
                        timer_d     = '0;
                        walk_flag_d = 1'b0;
                    end
                end
                ST_ALLRED: begin
                    if (timer_inc == 8'(T_ARED)) begin
                        state_d     = ST_GREEN;
                        timer_d     = '0;
                        active_d    = rr_next;
                        walk_flag_d = |(ped_lat_q & (ONE << rr_next));
                        // A request arriving in the entry cycle stays latched.
                        ped_lat_d   = (ped_lat_q & ~(ONE << rr_next)) | ped_req_i;
                    end
                end
                default: begin
                    state_d = ST_GREEN;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are built from next-state values so they register with the state.
    always_comb begin
        act_mask_d = ONE << active_d;
        green_d    = (state_d == ST_GREEN)  ? act_mask_d : '0;
        yellow_d   = (state_d == ST_YELLOW) ? act_mask_d : '0;
        red_d      = ~(green_d | yellow_d);
        walk_d     = ((state_d == ST_GREEN) && walk_flag_d) ? act_mask_d : '0;
        case (state_d)
            ST_GREEN:  rem = (timer_d < 8'(T_GMIN)) ? 8'(T_GMIN) - timer_d
                                                    : 8'(T_GMAX) - timer_d;
            ST_YELLOW: rem = 8'(T_YEL) - timer_d;
            ST_ALLRED: rem = 8'(T_ARED) - timer_d;
            default:   rem = '0;
        endcase
        cd_d = (rem > 8'd15) ? 4'd15 : rem[3:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_GREEN;
            presc_q     <= '0;
            timer_q     <= '0;
            active_q    <= '0;
            ped_lat_q   <= '0;
            walk_flag_q <= 1'b0;
            green_o     <= ONE;
            yellow_o    <= '0;
            red_o       <= ~ONE;
            walk_o      <= '0;
            active_o    <= '0;
            countdown_o <= CD_RST;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            timer_q     <= timer_d;
            active_q    <= active_d;
            ped_lat_q   <= ped_lat_d;
            walk_flag_q <= walk_flag_d;
            green_o     <= green_d;
            yellow_o    <= yellow_d;
            red_o       <= red_d;
            walk_o      <= walk_d;
            active_o    <= active_d;
            countdown_o <= cd_d;
        end
    end

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed bench for semaforo_multi with a fast tick (TICK_DIV=4) and short phases.
module tb_semaforo_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] sensor, ped_req;
    logic [1:0] green, yellow, red, walk;
    logic [2:0] active;
    logic [3:0] countdown;
    int         cyc, n_chk, n_bad;
    logic [1:0] yel_or;

    always #5 clk = ~clk;

    semaforo_multi #(
        .N_APP(2), .TICK_DIV(4), .T_GMIN(3), .T_GMAX(6), .T_YEL(2), .T_ARED(1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .sensor_i(sensor), .ped_req_i(ped_req),
        .green_o(green), .yellow_o(yellow), .red_o(red), .walk_o(walk),
        .active_o(active), .countdown_o(countdown)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Two reset edges, then release; the current cycle becomes cycle 0.
    task automatic start();
        rst = 1'b1; enable = 1'b1; sensor = 2'b00; ped_req = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".green"},  32'(green),     32'h1);
        check({tag, ".red"},    32'(red),       32'h2);
        check({tag, ".yellow"}, 32'(yellow),    32'h0);
        check({tag, ".walk"},   32'(walk),      32'h0);
        check({tag, ".active"}, 32'(active),    32'h0);
        check({tag, ".cd"},     32'(countdown), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; enable = 1'b1; sensor = 2'b00; ped_req = 2'b00;

        // Reset values and no-demand green extension
        start();
        check_reset("rst");
        yel_or = 2'b00;
        for (int c = 1; c <= 30; c++) begin
            goto(c);
            yel_or |= yellow;
            if (c == 4)  check("nd.cd4",  32'(countdown), 32'd2);
            if (c == 12) check("nd.cd12", 32'(countdown), 32'd3);
            if (c == 23) check("nd.cd23", 32'(countdown), 32'd1);
            if (c == 24) begin
                check("nd.cd24",    32'(countdown), 32'd3);
                check("nd.green24", 32'(green),     32'h1);
            end
        end
        check("nd.no_yellow", 32'(yel_or), 32'h0);

        // Vehicle on approach 1
        start();
        sensor = 2'b10;
        goto(11); check("s1.yel11",   32'(yellow),    32'h0);
        goto(12); check("s1.yel12",   32'(yellow),    32'h1);
                  check("s1.red12",   32'(red),       32'h2);
                  check("s1.cd12",    32'(countdown), 32'd2);
        goto(19); check("s1.yel19",   32'(yellow),    32'h1);
        goto(20); check("s1.red20",   32'(red),       32'h3);
                  check("s1.cd20",    32'(countdown), 32'd1);
        goto(23); check("s1.green23", 32'(green),     32'h0);
        goto(24); check("s1.green24", 32'(green),     32'h2);
                  check("s1.red24",   32'(red),       32'h1);
                  check("s1.act24",   32'(active),    32'd1);
                  check("s1.walk24",  32'(walk),      32'h0);
                  check("s1.cd24",    32'(countdown), 32'd3);

        // One-cycle pedestrian request on approach 1, then back to approach 0
        start();
        goto(2);  ped_req = 2'b10;
        goto(3);  ped_req = 2'b00;
        goto(12); check("pd.yel12",   32'(yellow), 32'h1);
        goto(24); check("pd.green24", 32'(green),  32'h2);
                  check("pd.walk24",  32'(walk),   32'h2);
                  check("pd.act24",   32'(active), 32'd1);
        sensor = 2'b01;
        goto(35); check("pd.walk35",  32'(walk),   32'h2);
        goto(36); check("pd.yel36",   32'(yellow), 32'h2);
                  check("pd.walk36",  32'(walk),   32'h0);
        goto(48); check("pd.green48", 32'(green),  32'h1);
                  check("pd.act48",   32'(active), 32'd0);
                  check("pd.walk48",  32'(walk),   32'h0);
        goto(60); check("pd.yel60",   32'(yellow), 32'h0);
                  check("pd.cd60",    32'(countdown), 32'd3);

        // Enable held low during yellow stretches the phase
        start();
        sensor = 2'b10;
        goto(12); check("en.yel12",   32'(yellow),    32'h1);
        goto(13); enable = 1'b0;
        goto(20); check("en.yel20",   32'(yellow),    32'h1);
                  check("en.cd20",    32'(countdown), 32'd2);
        goto(23); enable = 1'b1;
        goto(26); check("en.cd26",    32'(countdown), 32'd1);
        goto(29); check("en.yel29",   32'(yellow),    32'h1);
        goto(30); check("en.red30",   32'(red),       32'h3);
        goto(33); check("en.green33", 32'(green),     32'h0);
        goto(34); check("en.green34", 32'(green),     32'h2);
                  check("en.act34",   32'(active),    32'd1);

        // Reset during all-red drops the pending pedestrian call
        start();
        goto(2);  ped_req = 2'b10;
        goto(3);  ped_req = 2'b00;
        goto(21); check("ar.red21", 32'(red), 32'h3);
                  rst = 1'b1; ped_req = 2'b10;
        goto(22); check_reset("ar.rst");
        rst = 1'b0; ped_req = 2'b00; cyc = 0;
        goto(12); check("ar.yel12",   32'(yellow), 32'h0);
                  check("ar.green12", 32'(green),  32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 Parameter N_APP, default 2, number of approaches (legal 2..8).
REQ-002 Parameter TICK_DIV, default 50_000_000, clk cycles per timing tick (>=2).
REQ-003 Parameter T_GMIN, default 5, minimum green length in ticks (>=1).
REQ-004 Parameter T_GMAX, default 15, maximum green length in ticks (>T_GMIN, <=255).
REQ-005 Parameter T_YEL, default 3, yellow length in ticks (>=1).
REQ-006 Parameter T_ARED, default 1, all-red clearance length in ticks (>=1).
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  1 = timing advances; 0 = freeze prescaler and phase timer.
REQ-010 sensor  in  N_APP  level, bit i = vehicle present on approach i.
REQ-011 ped_req  in  N_APP  pulse or level, bit i = pedestrian crossing request on approach i.
REQ-012 green / yellow / red  out  N_APP each  one-hot-per-approach lamp drives, registered.
REQ-013 walk  out  N_APP  pedestrian walk lamp per approach, registered.
REQ-014 active  out  3  index of approach currently holding right of way.
REQ-015 countdown  out  4  ticks remaining in current phase, saturated at 15, drives 7-seg.

Function
REQ-016 Prescaler counts 0..TICK_DIV-1 while enable=1; tick=1 in the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-017 FSM states: GREEN, YELLOW, ALLRED; phase timer increments on each tick, clears on state change.
REQ-018 Demand for approach i = sensor[i] OR ped_lat[i]; "other demand" = demand on any approach other than active.
REQ-019 GREEN -> YELLOW on a tick where timer+1 >= T_GMIN and other demand=1, or where timer+1 = T_GMAX and other demand=1.
REQ-020 GREEN with no other demand at timer+1 = T_GMAX: stay GREEN, timer clears to 0 (green extension).
REQ-021 YELLOW -> ALLRED on the tick where timer+1 = T_YEL; ALLRED -> GREEN on the tick where timer+1 = T_ARED.
REQ-022 On ALLRED -> GREEN, active = first index after active (mod N_APP, round-robin) with demand; if none, active+1 mod N_APP.
REQ-023 Lamps: GREEN -> green[active]=1; YELLOW -> yellow[active]=1; all other bits of that approach's set red=1; ALLRED -> red all ones; exactly one lamp per approach at all times.
REQ-024 ped_lat[i] set by ped_req[i]=1 any cycle; cleared in the cycle GREEN is entered for i; set and clear same cycle -> set wins.
REQ-025 walk[active]=1 for the whole GREEN phase if ped_lat[active] was 1 at GREEN entry; walk=0 in YELLOW, ALLRED and on all other approaches.
REQ-026 countdown: GREEN timer<T_GMIN -> T_GMIN-timer; GREEN otherwise -> T_GMAX-timer; YELLOW -> T_YEL-timer; ALLRED -> T_ARED-timer; saturate at 15.
REQ-027 All outputs registered; a state change caused by a tick at cycle k is visible at cycle k+1.
REQ-028 enable=0: prescaler, timer, state held; ped_lat still captures requests.

Reset
REQ-029 rst=1: state GREEN, active=0, timer=0, prescaler=0, ped_lat=0.
REQ-030 Outputs the cycle after rst: green=...0001, red=~green, yellow=0, walk=0, active=0, countdown=min(T_GMIN,15).
REQ-031 rst asserted in any state/phase overrides all other inputs in that cycle.

Verification (N_APP=2, TICK_DIV=4, T_GMIN=3, T_GMAX=6, T_YEL=2, T_ARED=1; cycle 0 = first cycle after rst release, enable=1)
REQ-032 Reset: after rst -> green=01, red=10, yellow=00, walk=00, countdown=3.
REQ-033 No demand: sensor=00 -> green=01 held; at cycle 24 timer clears, countdown returns to 3, no yellow ever.
REQ-034 sensor=10 from cycle 0 -> yellow=01 at cycle 12, red=11 at cycle 20, green=10, active=1 at cycle 24.
REQ-035 One-cycle ped_req=10 at cycle 2, sensor=00 -> same timing as REQ-034; walk=10 from cycle 24 until yellow; ped_lat[1] cleared at cycle 24.
REQ-036 sensor=10, enable=0 for cycles 13..22 -> yellow extends 10 cycles; red=11 at cycle 30, green=10 at cycle 34.
REQ-037 rst pulsed at cycle 21 (ALLRED) -> cycle 22 outputs match REQ-032; pending ped_lat cleared.
